iz_param_loader: RTL and testbench
==================================

Name: iz_param_loader

Overview:
- Byte-serial loader that produces the four 16-bit Izhikevich parameters (a, b, c, d) and the params_ready qualifier consumed by the neuron core.
- Sits between the 8-pin external configuration bus and the neuron; the write side of the neuron's parameter interface.
- Receives framed, checksummed bytes, stages them in shadow registers, and commits atomically so the neuron never sees a partially loaded set.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1024, maximum clk cycles allowed between accepted bytes inside a frame before the frame is aborted.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- data_in  input  8  configuration byte
- data_valid  input  1  data_in valid this cycle; one byte per high cycle
- param_a  output  16  active a (x64 fixed point, signed)
- param_b  output  16  active b (x64, signed)
- param_c  output  16  active c (x64, signed)
- param_d  output  16  active d (x64, signed)
- params_ready  output  1  active parameter set valid and stable
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse on a successful commit
- frame_error  output  1  one-cycle pulse on checksum failure or timeout

Behaviour:
- Reset values:
  - param_a..param_d = 0; params_ready = 0; busy = 0; frame_done = 0; frame_error = 0.
  - Internal: have_valid = 0, shadow registers = 0, byte_cnt = 0, checksum accumulator = 0, timeout counter = 0, state = IDLE.
- Frame format: SYNC_BYTE, then 8 payload bytes in the order a_hi, a_lo, b_hi, b_lo, c_hi, c_lo, d_hi, d_lo, then 1 checksum byte. The checksum is the XOR of the 8 payload bytes.
- State IDLE:
  - data_valid with data_in == SYNC_BYTE moves to PAYLOAD and clears byte_cnt, accumulator and timeout counter.
  - Any other byte is ignored.
- State PAYLOAD:
  - Each data_valid writes byte byte_cnt into the shadow registers, XORs it into the accumulator and increments byte_cnt.
  - The byte after byte_cnt reaches 7 moves to CHECK.
  - SYNC_BYTE inside a frame is ordinary data.
- State CHECK:
  - The next data_valid byte is compared with the accumulator, then the block returns to IDLE.
  - On a match, in the following cycle: param_a..d <= shadow, have_valid = 1, frame_done pulses.
  - On a mismatch, in the following cycle: frame_error pulses, active params stay unchanged, have_valid stays unchanged.
- Timeout:
  - In PAYLOAD or CHECK, the counter increments on each cycle without data_valid and clears on data_valid.
  - When it reaches TIMEOUT_CYCLES-1 with no byte: abort to IDLE, frame_error pulses next cycle, active params unchanged.
- busy = 1 while in PAYLOAD or CHECK, registered; it rises the cycle after the SYNC byte is accepted.
- params_ready = have_valid & ~busy, registered.
  - It drops the cycle after SYNC is accepted, so the neuron pauses during the load.
  - It returns high in the commit cycle on success.
  - On error it restores the previous have_valid value in the error-pulse cycle.
- Latency: last checksum byte at cycle N -> outputs updated, params_ready high and frame_done high at cycle N+1.
- frame_done and frame_error are never high in the same cycle.
- Back-to-back frames: a SYNC byte accepted in the cycle after the commit starts a new frame immediately.
- Reset mid-frame: immediate return to reset values, including have_valid = 0; no pulse is emitted.

Optional Feature:
- Macro: IZ_LOADER_DEFAULTS_EN.
- Defined: reset loads regular-spiking defaults a = 16'h0001, b = 16'h000D, c = 16'hEFC0 (-65*64), d = 16'h0200 (8*64), with have_valid = 1 and params_ready = 1 from the first cycle after reset. A reset mid-frame restores these defaults.
- Undefined: all parameters reset to 0 and params_ready = 0 until the first good frame.

Test Plan:
- Good frame: A5,00,01,00,0D,EF,C0,02,00,21 on consecutive cycles -> the cycle after 21: a=0001, b=000D, c=EFC0, d=0200, params_ready=1, frame_done one cycle, busy=0.
- Bad checksum: same payload with checksum 22 after a prior good load -> frame_error pulse; params keep their prior values; params_ready low during the frame, then back to 1.
- Idle filtering: bytes 00,FF,5A then the good frame -> leading bytes ignored, correct commit.
- Timeout: A5,00,01 then 1024 idle cycles -> frame_error pulse, busy=0, params unchanged; a following good frame commits.
- Reset mid-frame: A5,00,01,00 then reset for 1 cycle -> all outputs at reset values (defaults if IZ_LOADER_DEFAULTS_EN); the next good frame commits normally.
- Embedded sync and gaps: payload containing A5 bytes sent with idle gaps of 5 cycles -> payload byte taken as data; commit correct; params_ready low throughout the frame.

Source files
------------

// File: rtl/iz_param_loader.sv
// rtl/iz_param_loader.sv - byte-serial loader for the Izhikevich a/b/c/d parameter set
//
// Frame: SYNC_BYTE, a_hi, a_lo, b_hi, b_lo, c_hi, c_lo, d_hi, d_lo, checksum (XOR of the payload).
// Payload bytes go into shadow registers. The active set is committed in one cycle, so the neuron
// never sees a partially loaded set.
// Optional build macro: IZ_LOADER_DEFAULTS_EN (reset loads regular-spiking defaults, params_ready=1).
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   data_in[7:0], data_valid         configuration byte stream, one byte per valid cycle
//   param_a..param_d[15:0]           active parameter set (signed, x64 fixed point)
//   params_ready                     active set valid and not being reloaded
//   busy                             frame in progress
//   frame_done, frame_error          one-cycle pulses: commit / checksum failure or timeout
module iz_param_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic [15:0] param_a,
    output logic [15:0] param_b,
    output logic [15:0] param_c,
    output logic [15:0] param_d,
    output logic        params_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

`ifdef IZ_LOADER_DEFAULTS_EN
    localparam logic [15:0] RST_A     = 16'h0001;
    localparam logic [15:0] RST_B     = 16'h000D;
    localparam logic [15:0] RST_C     = 16'hEFC0;
    localparam logic [15:0] RST_D     = 16'h0200;
    localparam logic        RST_VALID = 1'b1;
`else
    localparam logic [15:0] RST_A     = 16'h0000;
    localparam logic [15:0] RST_B     = 16'h0000;
    localparam logic [15:0] RST_C     = 16'h0000;
    localparam logic [15:0] RST_D     = 16'h0000;
    localparam logic        RST_VALID = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [2:0]    byte_cnt;
    logic [7:0]    acc;
    logic [TW-1:0] tcnt;
    logic [63:0]   shadow;
    logic          have_valid;
    logic          have_valid_next;
    logic          start;
    logic          take;
    logic          commit;
    logic          fail;
    logic          timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        take       = 1'b0;
        commit     = 1'b0;
        fail       = 1'b0;
        // The abort fires on the idle cycle that would push the gap to TIMEOUT_CYCLES.
        timeout    = (tcnt == TW'(TIMEOUT_CYCLES - 1)) && !data_valid;
        case (state)
            IDLE: begin
                if (data_valid && data_in == SYNC_BYTE) begin
                    state_next = PAYLOAD;
                    start      = 1'b1;
                end
            end
            PAYLOAD: begin
                if (data_valid) begin
                    take = 1'b1;
                    if (byte_cnt == 3'd7) begin
                        state_next = CHECK;
                    end
                end else if (timeout) begin
                    state_next = IDLE;
                    fail       = 1'b1;
                end
            end
            CHECK: begin
                if (data_valid) begin
                    state_next = IDLE;
                    if (data_in == acc) begin
                        commit = 1'b1;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (timeout) begin
                    state_next = IDLE;
                    fail       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        have_valid_next = have_valid | commit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            param_a      <= RST_A;
            param_b      <= RST_B;
            param_c      <= RST_C;
            param_d      <= RST_D;
            have_valid   <= RST_VALID;
            params_ready <= RST_VALID;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
            shadow       <= '0;
            byte_cnt     <= '0;
            acc          <= '0;
            tcnt         <= '0;
        end else begin
            frame_done   <= commit;
            frame_error  <= fail;
            have_valid   <= have_valid_next;
            busy         <= (state_next != IDLE);
            // Registered from next-state values so ready drops with busy and returns with the commit.
            params_ready <= have_valid_next && (state_next == IDLE);

            if (start) begin
                byte_cnt <= '0;
                acc      <= '0;
                tcnt     <= '0;
            end else if (state != IDLE) begin
                if (data_valid) begin
                    tcnt <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end

            if (take) begin
                // Byte 0 (a_hi) lands in the top byte of the shadow word.
                shadow[{~byte_cnt, 3'b000} +: 8] <= data_in;
                acc                              <= acc ^ data_in;
                byte_cnt                         <= byte_cnt + 1'b1;
            end

            if (commit) begin
                param_a <= shadow[63:48];
                param_b <= shadow[47:32];
                param_c <= shadow[31:16];
                param_d <= shadow[15:0];
            end
        end
    end
endmodule

// File: tb/tb_iz_param_loader.sv
// tb/tb_iz_param_loader.sv - scoreboard bench for iz_param_loader with frame-level reference model
module tb_iz_param_loader;
`ifdef IZ_LOADER_DEFAULTS_EN
    localparam logic [63:0] RST_SET = 64'h0001_000D_EFC0_0200;
    localparam logic        RST_HV  = 1'b1;
`else
    localparam logic [63:0] RST_SET = 64'h0;
    localparam logic        RST_HV  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic        data_valid = 1'b0;
    logic [15:0] param_a, param_b, param_c, param_d;
    logic        params_ready, busy, frame_done, frame_error;

    iz_param_loader dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .param_a      (param_a),
        .param_b      (param_b),
        .param_c      (param_c),
        .param_d      (param_d),
        .params_ready (params_ready),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        done;
        logic [63:0] set;
        logic        hv;
        int          cycle;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        rst_q = 1'b1;
    int          win_start = 1;
    int          win_end = 0;
    logic [63:0] m_set = RST_SET;
    logic        m_hv = RST_HV;
    logic [63:0] cur_set = RST_SET;
    logic        cur_hv = RST_HV;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    // Monitor: every cycle either a reset check, a pulse popped from the scoreboard, or a steady-state check.
    always @(negedge clk) begin
        logic [63:0] act;
        exp_t        e;
        act = {param_a, param_b, param_c, param_d};
        if (rst_q) begin
            checks++;
            if (act !== RST_SET || params_ready !== RST_HV || busy !== 1'b0 ||
                frame_done !== 1'b0 || frame_error !== 1'b0) begin
                failures++;
                $display("FAIL reset_state cyc=%0d got params=%h rdy=%b busy=%b done=%b err=%b want params=%h rdy=%b",
                         cyc, act, params_ready, busy, frame_done, frame_error, RST_SET, RST_HV);
            end
            cur_set = RST_SET;
            cur_hv  = RST_HV;
        end else if (frame_done === 1'b1 || frame_error === 1'b1) begin
            checks++;
            if (frame_done && frame_error) begin
                failures++;
                $display("FAIL pulse_exclusive cyc=%0d got done=1 err=1 want one of them", cyc);
            end
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse cyc=%0d got done=%b err=%b want no pulse", cyc, frame_done, frame_error);
            end else begin
                e = q.pop_front();
                if (frame_done !== e.done || cyc != e.cycle) begin
                    failures++;
                    $display("FAIL pulse_kind cyc=%0d got done=%b err=%b want done=%b at cyc=%0d",
                             cyc, frame_done, frame_error, e.done, e.cycle);
                end
                checks++;
                if (act !== e.set || params_ready !== e.hv || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL pulse_outputs cyc=%0d got params=%h rdy=%b busy=%b want params=%h rdy=%b busy=0",
                             cyc, act, params_ready, busy, e.set, e.hv);
                end
                cur_set = e.set;
                cur_hv  = e.hv;
            end
        end else begin
            checks++;
            if (act !== cur_set) begin
                failures++;
                $display("FAIL params_stable cyc=%0d got %h want %h", cyc, act, cur_set);
            end
            checks++;
            if (cyc >= win_start && cyc <= win_end) begin
                if (busy !== 1'b1 || params_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL in_frame cyc=%0d got busy=%b rdy=%b want busy=1 rdy=0", cyc, busy, params_ready);
                end
            end else if (busy !== 1'b0 || params_ready !== cur_hv) begin
                failures++;
                $display("FAIL idle_state cyc=%0d got busy=%b rdy=%b want busy=0 rdy=%b", cyc, busy, params_ready, cur_hv);
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] b);
        @(posedge clk);
        #1;
        data_valid = v;
        data_in    = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom));
    endtask

    task automatic start_frame();
        drive(1'b1, 8'hA5);
        win_start = cyc + 1;
        win_end   = 32'h7fff_ffff;
    endtask

    // cs_force < 0 sends the correct checksum; otherwise the given byte is sent as-is.
    task automatic send_frame(input logic [63:0] pl, input int gap, input int gap_last, input int cs_force);
        logic [7:0] x;
        logic [7:0] csb;
        exp_t       e;
        x = 8'h00;
        for (int i = 0; i < 8; i++) x = x ^ pl[63-8*i -: 8];
        csb = (cs_force < 0) ? x : 8'(cs_force);
        start_frame();
        for (int i = 0; i < 8; i++) begin
            idle(gap);
            drive(1'b1, pl[63-8*i -: 8]);
        end
        idle(gap_last);
        drive(1'b1, csb);
        win_end = cyc;
        if (csb == x) begin
            m_set = pl;
            m_hv  = 1'b1;
        end
        e.done  = (csb == x);
        e.set   = m_set;
        e.hv    = m_hv;
        e.cycle = cyc + 1;
        q.push_back(e);
    endtask

    task automatic send_timeout(input int nbytes);
        exp_t e;
        start_frame();
        for (int i = 0; i < nbytes; i++) drive(1'b1, 8'($urandom));
        idle(1024);
        win_end = cyc;
        e.done  = 1'b0;
        e.set   = m_set;
        e.hv    = m_hv;
        e.cycle = cyc + 1;
        q.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $fatal(1, "watchdog");
    end

    localparam logic [63:0] GOOD = 64'h0001_000D_EFC0_0200;

    initial begin
        logic [63:0] pl;
        logic [7:0]  g;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);

        drive(1'b1, 8'h00);
        drive(1'b1, 8'hFF);
        drive(1'b1, 8'h5A);
        send_frame(GOOD, 0, 0, 8'h21);
        idle(2);
        send_frame(GOOD, 0, 0, 8'h22);
        idle(2);
        send_timeout(2);
        idle(2);
        send_frame(64'h1234_8765_0F0F_F0F0, 0, 0, -1);
        idle(2);

        start_frame();
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h01);
        drive(1'b1, 8'h00);
        @(posedge clk);
        #1;
        win_end    = cyc;
        data_valid = 1'b0;
        reset      = 1'b1;
        m_set      = RST_SET;
        m_hv       = RST_HV;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);
        send_frame(GOOD, 0, 0, 8'h21);
        idle(1);

        send_frame(64'hA5A5_0010_A500_01A5, 5, 5, -1);
        send_frame(64'hCAFE_BEEF_0123_4567, 0, 1023, -1);
        send_timeout(8);
        send_frame(64'h7FFF_8000_FFFF_0001, 0, 0, -1);
        send_frame(64'h0102_0304_0506_0708, 0, 0, -1);

        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                drive(1'b1, g);
            end
            pl = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) pl[39:32] = 8'hA5;
            if ($urandom_range(0, 3) == 0) begin
                g = 8'h00;
                for (int i = 0; i < 8; i++) g = g ^ pl[63-8*i -: 8];
                send_frame(pl, $urandom_range(0, 2), $urandom_range(0, 2), int'(g ^ 8'($urandom_range(1, 255))));
            end else begin
                send_frame(pl, $urandom_range(0, 2), $urandom_range(0, 2), -1);
            end
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 4));
        end

        idle(10);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
